// File: rtl/qos_aging_queue_if.sv
// Shared QoS types and the request-path bundle between an upstream source,
// the per-requester aging queue and the fixed-priority arbiter.
package qos_aging_queue_pkg;

    typedef enum logic [1:0] {
        QOS_MEDIUM      = 2'd0,
        QOS_MEDIUM_HIGH = 2'd1,
        QOS_HIGH        = 2'd2,
        QOS_CRITICAL    = 2'd3
    } qos_level_e;

    typedef struct packed {
        logic       urgent;
        logic [2:0] stream_id;
        qos_level_e qos_level;
    } qos_config_t;

endpackage

interface qos_aging_queue_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 64
);
    import qos_aging_queue_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  flush_i;
    logic                  enq_valid_i;
    logic                  enq_ready_o;
    qos_config_t           enq_qos_config_i;
    logic [DATA_WIDTH-1:0] enq_data_i;
    logic                  req_valid_o;
    logic                  req_ready_i;
    qos_config_t           qos_config_o;
    logic [DATA_WIDTH-1:0] req_data_o;
    logic [CW-1:0]         count_o;
    logic                  escalated_o;

    modport slave (
        input  flush_i, enq_valid_i, enq_qos_config_i, enq_data_i, req_ready_i,
        output enq_ready_o, req_valid_o, qos_config_o, req_data_o, count_o, escalated_o
    );

    modport master (
        output flush_i, enq_valid_i, enq_qos_config_i, enq_data_i, req_ready_i,
        input  enq_ready_o, req_valid_o, qos_config_o, req_data_o, count_o, escalated_o
    );

endinterface

// File: rtl/qos_aging_queue.sv
// In-order request buffer feeding one arbiter input; the head entry's QoS
// level is raised one step per AGE_THRESHOLD consecutive stalled cycles.
module qos_aging_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned AGE_THRESHOLD = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    qos_aging_queue_if.slave bus
);
    import qos_aging_queue_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = $clog2(AGE_THRESHOLD + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] AGE_LAST   = AW'(AGE_THRESHOLD - 1);

    qos_config_t           cfg_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] age;
    logic          escalated;

    logic          not_empty;
    logic          not_full;
    logic          enq_ready;
    logic          push;
    logic          pop;
    logic          stall;
    logic          head_critical;
    logic          age_hit;
    qos_config_t   head_cfg;

    function automatic qos_level_e step_level(input qos_level_e lvl);
        case (lvl)
            QOS_MEDIUM:      return QOS_MEDIUM_HIGH;
            QOS_MEDIUM_HIGH: return QOS_HIGH;
            default:         return QOS_CRITICAL;
        endcase
    endfunction

    always_comb begin
        not_empty     = (count != '0);
        not_full      = (count != FULL_COUNT);
        // Ready is forced low while reset is held so nothing is accepted then.
        enq_ready     = rst_ni & not_full;
        push          = bus.enq_valid_i & enq_ready & ~bus.flush_i;
        pop           = not_empty & bus.req_ready_i & ~bus.flush_i;
        head_cfg      = cfg_mem[rd_ptr];
        head_critical = (head_cfg.qos_level == QOS_CRITICAL);
        stall         = not_empty & ~bus.req_ready_i & ~bus.flush_i;
        age_hit       = stall & ~head_critical & (age == AGE_LAST);
    end

    always_comb begin
        bus.enq_ready_o  = enq_ready;
        bus.req_valid_o  = not_empty;
        bus.count_o      = count;
        bus.qos_config_o = '0;
        bus.req_data_o   = '0;
        bus.escalated_o  = 1'b0;
        if (not_empty) begin
            bus.qos_config_o = head_cfg;
            bus.req_data_o   = data_mem[rd_ptr];
            bus.escalated_o  = escalated;
        end
    end

    // Escalation rewrites the head slot in place; it never collides with a
    // push because the write pointer only equals the read pointer when the
    // buffer is empty (no escalation) or full (no push).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cfg_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                cfg_mem[wr_ptr]  <= bus.enq_qos_config_i;
                data_mem[wr_ptr] <= bus.enq_data_i;
            end
            if (age_hit) begin
                cfg_mem[rd_ptr].qos_level <= step_level(head_cfg.qos_level);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age       <= '0;
            escalated <= 1'b0;
        end else if (bus.flush_i || pop || !not_empty) begin
            age       <= '0;
            escalated <= 1'b0;
        end else if (head_critical) begin
            age <= '0;
        end else if (stall) begin
            if (age_hit) begin
                age       <= '0;
                escalated <= 1'b1;
            end else begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qos_aging_queue.sv
// Directed bench for qos_aging_queue with a queue-based scoreboard and a
// small head-aging model checked every cycle.
module tb_qos_aging_queue;
    import qos_aging_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned AGE   = 16;

    typedef struct {
        qos_config_t     cfg;
        logic [DW-1:0]   data;
    } entry_t;

    logic clk;
    logic rst_n;

    qos_aging_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    qos_aging_queue #(
        .DEPTH(DEPTH),
        .DATA_WIDTH(DW),
        .AGE_THRESHOLD(AGE)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus)
    );

    entry_t     sb[$];
    qos_level_e h_lvl;
    int         h_age;
    bit         h_esc;
    int         n_assert;
    int         n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic qos_config_t mk_cfg(input logic urgent, input int sid, input qos_level_e lvl);
        qos_config_t c;
        c.urgent    = urgent;
        c.stream_id = 3'(sid);
        c.qos_level = lvl;
        return c;
    endfunction

    task automatic set_in(input logic enq, input qos_config_t cfg, input logic [DW-1:0] data,
                          input logic ready, input logic flush);
        bus.enq_valid_i      = enq;
        bus.enq_qos_config_i = cfg;
        bus.enq_data_i       = data;
        bus.req_ready_i      = ready;
        bus.flush_i          = flush;
    endtask

    task automatic model_clear();
        sb.delete();
        h_lvl = QOS_MEDIUM;
        h_age = 0;
        h_esc = 1'b0;
    endtask

    // Compare outputs against the model, advance the model for the coming
    // edge, then move to the next sample point (1 time unit after the edge).
    task automatic cycle();
        qos_config_t hc;
        entry_t      e;
        bit          was_empty;
        bit          popd;
        bit          pushd;
        check("count", 64'(bus.count_o), 64'(sb.size()));
        check("req_valid", 64'(bus.req_valid_o), 64'(sb.size() != 0));
        check("enq_ready", 64'(bus.enq_ready_o), 64'(sb.size() != DEPTH));
        if (sb.size() != 0) begin
            hc           = sb[0].cfg;
            hc.qos_level = h_lvl;
            check("head_data", bus.req_data_o, sb[0].data);
            check("head_cfg", 64'(bus.qos_config_o), 64'(hc));
            check("escalated", 64'(bus.escalated_o), 64'(h_esc));
        end else begin
            check("empty_data", bus.req_data_o, 64'd0);
            check("empty_cfg", 64'(bus.qos_config_o), 64'd0);
            check("empty_escalated", 64'(bus.escalated_o), 64'd0);
        end

        if (bus.flush_i) begin
            model_clear();
        end else begin
            was_empty = (sb.size() == 0);
            popd      = !was_empty && bus.req_ready_i;
            pushd     = bus.enq_valid_i && (sb.size() != DEPTH);
            if (!was_empty && !bus.req_ready_i && h_lvl != QOS_CRITICAL) begin
                h_age++;
                if (h_age == AGE) begin
                    h_lvl = qos_level_e'(int'(h_lvl) + 1);
                    h_age = 0;
                    h_esc = 1'b1;
                end
            end
            if (popd) begin
                void'(sb.pop_front());
                h_age = 0;
                h_esc = 1'b0;
            end
            if (pushd) begin
                e.cfg  = bus.enq_qos_config_i;
                e.data = bus.enq_data_i;
                sb.push_back(e);
            end
            if ((popd || was_empty) && sb.size() != 0) begin
                h_lvl = sb[0].cfg.qos_level;
                h_age = 0;
                h_esc = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.enq_valid_i = 1'b0;
        bus.req_ready_i = 1'b1;
        for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) cycle();
        check("drained", 64'(bus.count_o), 64'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_clear();
        rst_n = 1'b0;
        set_in(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset values while held in reset
        #2;
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_req_valid", 64'(bus.req_valid_o), 64'd0);
        check("rst_enq_ready", 64'(bus.enq_ready_o), 64'd0);
        check("rst_escalated", 64'(bus.escalated_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_enq_ready", 64'(bus.enq_ready_o), 64'd1);

        // Fill / drain: 0xA0..0xA4 with no grant, then grant every cycle
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, mk_cfg(1'b0, i, QOS_MEDIUM), 64'hA0 + 64'(i), 1'b0, 1'b0);
            cycle();
        end
        check("full_count", 64'(bus.count_o), 64'd4);
        check("full_enq_ready", 64'(bus.enq_ready_o), 64'd0);
        set_in(1'b1, mk_cfg(1'b1, 4, QOS_MEDIUM), 64'hA4, 1'b0, 1'b0);
        cycle();
        check("held_off_count", 64'(bus.count_o), 64'd4);
        bus.req_ready_i = 1'b1;
        cycle();
        check("first_pop_count", 64'(bus.count_o), 64'd3);
        check("first_pop_data", bus.req_data_o, 64'hA1);
        cycle();
        check("a4_accepted_count", 64'(bus.count_o), 64'd3);
        drain();

        // Escalation of a lone MEDIUM head
        set_in(1'b1, mk_cfg(1'b1, 5, QOS_MEDIUM), 64'hE0, 1'b0, 1'b0);
        cycle();
        bus.enq_valid_i = 1'b0;
        repeat (15) cycle();
        check("lvl_15", 64'(bus.qos_config_o.qos_level), 64'(QOS_MEDIUM));
        check("esc_15", 64'(bus.escalated_o), 64'd0);
        cycle();
        check("lvl_16", 64'(bus.qos_config_o.qos_level), 64'(QOS_MEDIUM_HIGH));
        check("esc_16", 64'(bus.escalated_o), 64'd1);
        repeat (16) cycle();
        check("lvl_32", 64'(bus.qos_config_o.qos_level), 64'(QOS_HIGH));
        repeat (16) cycle();
        check("lvl_48", 64'(bus.qos_config_o.qos_level), 64'(QOS_CRITICAL));
        repeat (20) cycle();
        check("lvl_hold", 64'(bus.qos_config_o.qos_level), 64'(QOS_CRITICAL));
        check("passthrough", 64'(bus.qos_config_o.stream_id), 64'd5);
        drain();
        check("esc_after_pop", 64'(bus.escalated_o), 64'd0);

        // Pop resets the age of the next head
        set_in(1'b1, mk_cfg(1'b0, 1, QOS_MEDIUM), 64'hB0, 1'b0, 1'b0);
        cycle();
        set_in(1'b1, mk_cfg(1'b1, 2, QOS_MEDIUM), 64'hB1, 1'b0, 1'b0);
        cycle();
        bus.enq_valid_i = 1'b0;
        repeat (9) cycle();
        bus.req_ready_i = 1'b1;
        cycle();
        bus.req_ready_i = 1'b0;
        check("newhead_data", bus.req_data_o, 64'hB1);
        check("newhead_esc", 64'(bus.escalated_o), 64'd0);
        repeat (15) cycle();
        check("newhead_lvl_15", 64'(bus.qos_config_o.qos_level), 64'(QOS_MEDIUM));
        cycle();
        check("newhead_lvl_16", 64'(bus.qos_config_o.qos_level), 64'(QOS_MEDIUM_HIGH));
        drain();

        // Back-to-back traffic across pointer wrap
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, mk_cfg(i[0], i, qos_level_e'(i % 3)), 64'h100 + 64'(i), 1'b1, 1'b0);
            cycle();
            check("wrap_count", 64'(bus.count_o), 64'd1);
            check("wrap_esc", 64'(bus.escalated_o), 64'd0);
        end
        drain();

        // Flush beats a same-cycle enqueue and clears escalation
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, mk_cfg(1'b0, 3, QOS_MEDIUM), 64'hC0 + 64'(i), 1'b0, 1'b0);
            cycle();
        end
        bus.enq_valid_i = 1'b0;
        repeat (14) cycle();
        check("pre_flush_esc", 64'(bus.escalated_o), 64'd1);
        set_in(1'b1, mk_cfg(1'b1, 7, QOS_HIGH), 64'hDD, 1'b0, 1'b1);
        check("flush_enq_ready", 64'(bus.enq_ready_o), 64'd1);
        cycle();
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        check("flush_count", 64'(bus.count_o), 64'd0);
        check("flush_req_valid", 64'(bus.req_valid_o), 64'd0);
        check("flush_esc", 64'(bus.escalated_o), 64'd0);
        cycle();
        set_in(1'b1, mk_cfg(1'b0, 6, QOS_HIGH), 64'hF0, 1'b0, 1'b0);
        cycle();
        drain();

        // Asynchronous reset in the middle of traffic with three entries held
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, mk_cfg(1'b1, i, QOS_MEDIUM_HIGH), 64'h70 + 64'(i), 1'b0, 1'b0);
            cycle();
        end
        check("mid_count", 64'(bus.count_o), 64'd3);
        bus.req_ready_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_count", 64'(bus.count_o), 64'd0);
        check("async_req_valid", 64'(bus.req_valid_o), 64'd0);
        check("async_enq_ready", 64'(bus.enq_ready_o), 64'd0);
        check("async_data", bus.req_data_o, 64'd0);
        check("async_cfg", 64'(bus.qos_config_o), 64'd0);
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        model_clear();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        set_in(1'b1, mk_cfg(1'b0, 4, QOS_MEDIUM), 64'h55, 1'b0, 1'b0);
        cycle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
